// File: rtl/mem_access_unit.sv
// Load/store unit between execute and data memory: byte strobes, lane shifting,
// load extension, two-beat split of word-crossing accesses and per-beat bus timeout.
module mem_access_unit #(
  parameter bit          ALLOW_MISALIGNED = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES   = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  LoadType,
  input  logic [1:0]  StoreType,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BEAT0 = 2'd1,
    S_BEAT1 = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  // Access size in bytes; 0 marks an illegal encoding.
  function automatic logic [2:0] load_size(input logic [2:0] t);
    case (t)
      3'b000:  load_size = 3'd4;
      3'b010:  load_size = 3'd1;
      3'b001:  load_size = 3'd1;
      3'b101:  load_size = 3'd2;
      3'b100:  load_size = 3'd2;
      default: load_size = 3'd0;
    endcase
  endfunction

  function automatic logic [2:0] store_size(input logic [1:0] t);
    case (t)
      2'b00:   store_size = 3'd4;
      2'b01:   store_size = 3'd1;
      2'b10:   store_size = 3'd2;
      default: store_size = 3'd0;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] t, input logic [31:0] raw);
    case (t)
      3'b000:  load_extend = raw;
      3'b010:  load_extend = {{24{raw[7]}}, raw[7:0]};
      3'b001:  load_extend = {24'd0, raw[7:0]};
      3'b101:  load_extend = {{16{raw[15]}}, raw[15:0]};
      3'b100:  load_extend = {16'd0, raw[15:0]};
      default: load_extend = 32'd0;
    endcase
  endfunction

  state_e        state_q, state_d;
  logic          we_q, we_d;
  logic [29:0]   addr_q, addr_d;
  logic [1:0]    off_q, off_d;
  logic [2:0]    ltype_q, ltype_d;
  logic          span_q, span_d;
  logic [63:0]   wd_q, wd_d;
  logic [7:0]    sb_q, sb_d;
  logic [31:0]   lo_q, lo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic [2:0]  req_size_s;
  logic        req_span_s, req_reject_s, accept_s;
  logic [31:0] req_masked_s;
  logic [3:0]  req_mask_s;
  logic [63:0] wd_s;
  logic [7:0]  sb_s;
  logic        in_beat_s, timeout_s, final_ack_s;
  logic [31:0] lo_s, hi_s, raw_s;

  // Request decode, store lane placement and load alignment
  always_comb begin
    req_size_s   = req_we ? store_size(StoreType) : load_size(LoadType);
    req_span_s   = (({1'b0, req_addr[1:0]} + req_size_s) > 3'd4);
    req_reject_s = (req_size_s == 3'd0) || (req_span_s && !ALLOW_MISALIGNED);
    accept_s     = req_valid & req_ready;
    case (req_size_s)
      3'd1:    begin req_masked_s = {24'd0, req_wdata[7:0]};  req_mask_s = 4'b0001; end
      3'd2:    begin req_masked_s = {16'd0, req_wdata[15:0]}; req_mask_s = 4'b0011; end
      default: begin req_masked_s = req_wdata;                req_mask_s = 4'b1111; end
    endcase
    wd_s        = {32'd0, req_masked_s} << {req_addr[1:0], 3'b000};
    sb_s        = {4'd0, req_mask_s} << req_addr[1:0];
    in_beat_s   = (state_q == S_BEAT0) || (state_q == S_BEAT1);
    timeout_s   = in_beat_s && !mem_ack && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    final_ack_s = mem_ack && (((state_q == S_BEAT0) && !span_q) || (state_q == S_BEAT1));
    lo_s        = (state_q == S_BEAT0) ? mem_rdata : lo_q;
    hi_s        = (state_q == S_BEAT1) ? mem_rdata : 32'd0;
    raw_s       = 32'({hi_s, lo_s} >> {off_q, 3'b000});
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; an ack in the timeout cycle still completes the beat
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) state_d = req_reject_s ? S_RESP : S_BEAT0;
        else          state_d = S_IDLE;
      end
      S_BEAT0: begin
        if (mem_ack)        state_d = span_q ? S_BEAT1 : S_RESP;
        else if (timeout_s) state_d = S_RESP;
        else                state_d = S_BEAT0;
      end
      S_BEAT1: begin
        if (mem_ack || timeout_s) state_d = S_RESP;
        else                      state_d = S_BEAT1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next-state: request latch, beat counter, read capture, response
  always_comb begin
    we_d = we_q; addr_d = addr_q; off_d = off_q; ltype_d = ltype_q; span_d = span_q;
    wd_d = wd_q; sb_d = sb_q; lo_d = lo_q; cnt_d = cnt_q; rdata_d = rdata_q; err_d = err_q;
    if (accept_s) begin
      we_d    = req_we;
      addr_d  = req_addr[31:2];
      off_d   = req_addr[1:0];
      ltype_d = LoadType;
      span_d  = req_span_s;
      wd_d    = req_we ? wd_s : 64'd0;
      sb_d    = req_we ? sb_s : 8'd0;
      cnt_d   = '0;
      err_d   = req_reject_s;
      rdata_d = 32'd0;
    end else if (in_beat_s) begin
      if (mem_ack) begin
        cnt_d = '0;
        lo_d  = lo_s;
        if (final_ack_s) begin
          err_d   = 1'b0;
          rdata_d = we_q ? 32'd0 : load_extend(ltype_q, raw_s);
        end else begin
          err_d   = err_q;
          rdata_d = rdata_q;
        end
      end else if (timeout_s) begin
        cnt_d   = '0;
        err_d   = 1'b1;
        rdata_d = 32'd0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q <= 1'b0; addr_q <= 30'd0; off_q <= 2'd0; ltype_q <= 3'd0; span_q <= 1'b0;
      wd_q <= 64'd0; sb_q <= 8'd0; lo_q <= 32'd0; cnt_q <= '0; rdata_q <= 32'd0; err_q <= 1'b0;
    end else begin
      we_q <= we_d; addr_q <= addr_d; off_q <= off_d; ltype_q <= ltype_d; span_q <= span_d;
      wd_q <= wd_d; sb_q <= sb_d; lo_q <= lo_d; cnt_q <= cnt_d; rdata_q <= rdata_d; err_q <= err_d;
    end
  end

  // Outputs decoded from state; the second beat addresses the next word with 32-bit wrap
  always_comb begin
    req_ready  = (state_q == S_IDLE) && !reset;
    mem_req    = in_beat_s;
    mem_we     = in_beat_s && we_q;
    mem_addr   = {addr_q + ((state_q == S_BEAT1) ? 30'd1 : 30'd0), 2'b00};
    if (in_beat_s && we_q) begin
      if (state_q == S_BEAT1) begin
        mem_wdata = wd_q[63:32];
        mem_wstrb = sb_q[7:4];
      end else begin
        mem_wdata = wd_q[31:0];
        mem_wstrb = sb_q[3:0];
      end
    end else begin
      mem_wdata = 32'd0;
      mem_wstrb = 4'b0000;
    end
    resp_valid = (state_q == S_RESP);
    resp_err   = (state_q == S_RESP) && err_q;
    resp_rdata = (state_q == S_RESP) ? rdata_q : 32'd0;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed requests push expected bus beats and
// responses; a bus responder and a response monitor pop and compare independently.
module tb_mem_access_unit;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_valid_na;
  logic        req_ready, req_ready_na;
  logic        req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  LoadType;
  logic [1:0]  StoreType;
  logic        resp_valid, resp_err, resp_valid_na, resp_err_na;
  logic [31:0] resp_rdata, resp_rdata_na;
  logic        mem_req, mem_we, mem_req_na, mem_we_na;
  logic [31:0] mem_addr, mem_wdata, mem_addr_na, mem_wdata_na;
  logic [3:0]  mem_wstrb, mem_wstrb_na;
  logic        mem_ack;
  logic        mem_ack_na = 1'b0;
  logic [31:0] mem_rdata;

  int nchk = 0, nerr = 0;
  int cyc = 0, accept_cyc = 0;
  int req_hi_cnt = 0, na_req_cnt = 0;
  resp_t exp_q[$];
  beat_t beat_q[$];
  beat_t cur;
  logic  in_beat = 1'b0;
  int    wait_n = 0;

  mem_access_unit #(.ALLOW_MISALIGNED(1'b1), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .LoadType(LoadType), .StoreType(StoreType),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata));

  mem_access_unit #(.ALLOW_MISALIGNED(1'b0), .TIMEOUT_CYCLES(4)) dut_na (
    .clk(clk), .reset(reset), .req_valid(req_valid_na), .req_ready(req_ready_na),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .LoadType(LoadType), .StoreType(StoreType),
    .resp_valid(resp_valid_na), .resp_rdata(resp_rdata_na), .resp_err(resp_err_na),
    .mem_req(mem_req_na), .mem_we(mem_we_na), .mem_addr(mem_addr_na), .mem_wdata(mem_wdata_na),
    .mem_wstrb(mem_wstrb_na), .mem_ack(mem_ack_na), .mem_rdata(mem_rdata));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bus responder: checks each beat's request fields and acks after the scripted delay
  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (mem_req) begin
      req_hi_cnt++;
      if (!in_beat) begin
        in_beat = 1'b1;
        if (beat_q.size() == 0) begin
          nchk++; nerr++;
          $display("FAIL unexpected_beat: got addr %h expected no bus request", mem_addr);
          cur = '{addr: mem_addr, we: mem_we, strb: mem_wstrb, wdata: mem_wdata, rdata: 32'd0, delay: 0};
        end else begin
          cur = beat_q.pop_front();
        end
        wait_n = cur.delay;
      end
      chk("mem_addr", mem_addr, cur.addr);
      chk("mem_we", {31'd0, mem_we}, {31'd0, cur.we});
      chk("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, cur.strb});
      chk("mem_wdata", mem_wdata, cur.wdata);
      if (wait_n == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = cur.rdata;
        in_beat   = 1'b0;
      end else begin
        wait_n--;
      end
    end else begin
      in_beat = 1'b0;
    end
    if (mem_req_na) na_req_cnt++;
  end

  // Response monitor
  always @(negedge clk) begin
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        nchk++; nerr++;
        $display("FAIL unexpected_resp: got rdata %h err %0b expected no response", resp_rdata, resp_err);
      end else begin
        resp_t e;
        e = exp_q.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
        chk("latency", 32'(cyc - accept_cyc), 32'(e.lat));
      end
    end
  end

  task automatic beat(input logic [31:0] a, input logic we, input logic [3:0] s,
                      input logic [31:0] wd, input logic [31:0] rd, input int d);
    beat_q.push_back('{addr: a, we: we, strb: s, wdata: wd, rdata: rd, delay: d});
  endtask

  task automatic expect_resp(input logic [31:0] rd, input logic err, input int lat);
    exp_q.push_back('{rdata: rd, err: err, lat: lat});
  endtask

  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] lt, input logic [1:0] st);
    int n;
    @(negedge clk);
    req_we = we; req_addr = a; req_wdata = wd; LoadType = lt; StoreType = st;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_accept", {31'd0, req_ready}, 32'd1);
    accept_cyc = cyc;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !req_ready) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("resp_arrived", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int n;
    reset = 1'b1; req_valid = 1'b0; req_valid_na = 1'b0; req_we = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; LoadType = 3'd0; StoreType = 2'd0;
    mem_ack = 1'b0; mem_rdata = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", {31'd0, req_ready}, 32'd1);

    // LB at 0x103: sign-extended top byte
    beat(32'h100, 1'b0, 4'b0000, 32'd0, 32'h80FF_1234, 0);
    expect_resp(32'hFFFF_FF80, 1'b0, 2);
    issue(1'b0, 32'h103, 32'd0, 3'b010, 2'b00); wait_done();

    // SH at 0x203 splits across two words
    beat(32'h200, 1'b1, 4'b1000, 32'hCD00_0000, 32'd0, 0);
    beat(32'h204, 1'b1, 4'b0001, 32'h0000_00AB, 32'd0, 0);
    expect_resp(32'd0, 1'b0, 3);
    issue(1'b1, 32'h203, 32'h0000_ABCD, 3'b000, 2'b10); wait_done();

    // LW at 0x101 split
    beat(32'h100, 1'b0, 4'b0000, 32'd0, 32'h4433_2211, 0);
    beat(32'h104, 1'b0, 4'b0000, 32'd0, 32'h8877_6655, 0);
    expect_resp(32'h5544_3322, 1'b0, 3);
    issue(1'b0, 32'h101, 32'd0, 3'b000, 2'b00); wait_done();

    // Illegal types: rejected without bus traffic
    expect_resp(32'd0, 1'b1, 1);
    issue(1'b0, 32'h0, 32'd0, 3'b111, 2'b00); wait_done();
    expect_resp(32'd0, 1'b1, 1);
    issue(1'b1, 32'h0, 32'h1234_5678, 3'b000, 2'b11); wait_done();

    // LBU with a 2-cycle ack wait
    beat(32'h100, 1'b0, 4'b0000, 32'd0, 32'h80FF_1234, 2);
    expect_resp(32'h0000_00FF, 1'b0, 4);
    issue(1'b0, 32'h102, 32'd0, 3'b001, 2'b00); wait_done();

    // LH / LHU aligned halves
    beat(32'h300, 1'b0, 4'b0000, 32'd0, 32'h80FF_1234, 0);
    expect_resp(32'hFFFF_80FF, 1'b0, 2);
    issue(1'b0, 32'h302, 32'd0, 3'b101, 2'b00); wait_done();
    beat(32'h300, 1'b0, 4'b0000, 32'd0, 32'h80FF_1234, 0);
    expect_resp(32'h0000_1234, 1'b0, 2);
    issue(1'b0, 32'h300, 32'd0, 3'b100, 2'b00); wait_done();

    // SW and SB lane placement
    beat(32'h400, 1'b1, 4'b1111, 32'hDEAD_BEEF, 32'd0, 0);
    expect_resp(32'd0, 1'b0, 2);
    issue(1'b1, 32'h400, 32'hDEAD_BEEF, 3'b000, 2'b00); wait_done();
    beat(32'h500, 1'b1, 4'b0010, 32'h0000_A500, 32'd0, 0);
    expect_resp(32'd0, 1'b0, 2);
    issue(1'b1, 32'h501, 32'h1234_56A5, 3'b000, 2'b01); wait_done();

    // LW crossing the top of the address space wraps to word 0
    beat(32'hFFFF_FFFC, 1'b0, 4'b0000, 32'd0, 32'hAABB_CCDD, 0);
    beat(32'h0000_0000, 1'b0, 4'b0000, 32'd0, 32'h1122_3344, 0);
    expect_resp(32'h3344_AABB, 1'b0, 3);
    issue(1'b0, 32'hFFFF_FFFE, 32'd0, 3'b000, 2'b00); wait_done();

    // Split LH with one-cycle waits on both beats
    beat(32'h700, 1'b0, 4'b0000, 32'd0, 32'h1122_3344, 1);
    beat(32'h704, 1'b0, 4'b0000, 32'd0, 32'h5566_7788, 1);
    expect_resp(32'hFFFF_8811, 1'b0, 5);
    issue(1'b0, 32'h703, 32'd0, 3'b101, 2'b00); wait_done();

    // Timeout: ack withheld, mem_req held exactly 4 cycles
    req_hi_cnt = 0;
    beat(32'h600, 1'b0, 4'b0000, 32'd0, 32'd0, 1000);
    expect_resp(32'd0, 1'b1, 5);
    issue(1'b0, 32'h600, 32'd0, 3'b000, 2'b00); wait_done();
    chk("timeout_req_cycles", 32'(req_hi_cnt), 32'd4);

    // Unit accepts again after the timeout
    beat(32'h800, 1'b0, 4'b0000, 32'd0, 32'h0000_007F, 0);
    expect_resp(32'h0000_007F, 1'b0, 2);
    issue(1'b0, 32'h800, 32'd0, 3'b010, 2'b00); wait_done();

    // Misaligned LW on the non-splitting instance is rejected with no bus request
    @(negedge clk);
    req_we = 1'b0; req_addr = 32'h101; LoadType = 3'b000; StoreType = 2'b00;
    chk("na_ready", {31'd0, req_ready_na}, 32'd1);
    req_valid_na = 1'b1;
    @(posedge clk);
    #1 req_valid_na = 1'b0;
    @(negedge clk);
    chk("na_resp_valid", {31'd0, resp_valid_na}, 32'd1);
    chk("na_resp_err", {31'd0, resp_err_na}, 32'd1);
    chk("na_resp_rdata", resp_rdata_na, 32'd0);
    @(negedge clk);
    chk("na_resp_pulse", {31'd0, resp_valid_na}, 32'd0);

    // Reset during BEAT1 discards the transaction
    beat(32'h100, 1'b0, 4'b0000, 32'd0, 32'h4433_2211, 0);
    beat(32'h104, 1'b0, 4'b0000, 32'd0, 32'd0, 1000);
    issue(1'b0, 32'h101, 32'd0, 3'b000, 2'b00);
    n = 0;
    while (!(mem_req && mem_addr == 32'h104) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("reached_beat1", mem_addr, 32'h104);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_mem_req", {31'd0, mem_req}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
    repeat (6) @(negedge clk);

    chk("beats_consumed", 32'(beat_q.size()), 32'd0);
    chk("resps_consumed", 32'(exp_q.size()), 32'd0);
    chk("na_never_req", 32'(na_req_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
